// File: rtl/regfile_write_scheduler_if.sv
// Write-port bundle between the writeback requesters, the scheduler and the register file.
// The slave view belongs to the scheduler; the master view belongs to whoever drives requests.
interface regfile_write_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ClearReq;
  logic                  Req0;
  logic                  Req1;
  logic [ADDR_WIDTH-1:0] WReg0;
  logic [ADDR_WIDTH-1:0] WReg1;
  logic [DATA_WIDTH-1:0] WData0;
  logic [DATA_WIDTH-1:0] WData1;
  logic                  Grant0;
  logic                  Grant1;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegNo;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;
  logic                  ClearDone;

  modport master (
    output ClearReq, Req0, Req1, WReg0, WReg1, WData0, WData1,
    input  Grant0, Grant1, RegWrite, WriteRegNo, WriteData, Busy, ClearDone
  );

  modport slave (
    input  ClearReq, Req0, Req1, WReg0, WReg1, WData0, WData1,
    output Grant0, Grant1, RegWrite, WriteRegNo, WriteData, Busy, ClearDone
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Owns the register file's single write port: zero sweep after reset or ClearReq,
// otherwise round-robin between the ALU (0) and load (1) writeback requesters.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  regfile_write_scheduler_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   cnt, cnt_next;
  logic                  last, last_next;

  logic                  grant0_q, grant0_next;
  logic                  grant1_q, grant1_next;
  logic                  reg_write_q, reg_write_next;
  logic [ADDR_WIDTH-1:0] reg_no_q, reg_no_next;
  logic [DATA_WIDTH-1:0] data_q, data_next;
  logic                  busy_q, busy_next;
  logic                  done_q, done_next;

  logic                  sweep_done;
  logic                  elig0, elig1;
  logic                  win_valid;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] win_reg;
  logic [DATA_WIDTH-1:0] win_data;

  assign sweep_done = (cnt == CNT_END);

  // A requester whose Grant is showing is still dropping Req; it must not be consumed twice.
  assign elig0     = bus.Req0 & ~grant0_q;
  assign elig1     = bus.Req1 & ~grant1_q;
  assign win_valid = elig0 | elig1;
  assign winner    = (elig0 & elig1) ? ~last : elig1;
  assign win_reg   = winner ? bus.WReg1  : bus.WReg0;
  assign win_data  = winner ? bus.WData1 : bus.WData0;

  // State register: every output is registered so the port is stable for a full cycle.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments keep all registers sampling pre-edge values together.
    if (Reset) begin
      state       <= CLEAR;
      cnt         <= '0;
      last        <= 1'b1;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      reg_write_q <= 1'b0;
      reg_no_q    <= '0;
      data_q      <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      last        <= last_next;
      grant0_q    <= grant0_next;
      grant1_q    <= grant1_next;
      reg_write_q <= reg_write_next;
      reg_no_q    <= reg_no_next;
      data_q      <= data_next;
      busy_q      <= busy_next;
      done_q      <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_done) state_next = RUN;
      RUN:     if (bus.ClearReq) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Output and datapath logic, evaluated one cycle ahead of the registered outputs.
  always_comb begin
    // NOTE: every target gets a default first so no path through this block infers a latch.
    cnt_next       = cnt;
    last_next      = last;
    grant0_next    = 1'b0;
    grant1_next    = 1'b0;
    reg_write_next = 1'b0;
    reg_no_next    = reg_no_q;
    data_next      = data_q;
    busy_next      = busy_q;
    done_next      = 1'b0;

    case (state)
      CLEAR: begin
        if (!sweep_done) begin
          reg_write_next = 1'b1;
          reg_no_next    = cnt[ADDR_WIDTH-1:0];
          data_next      = '0;
          cnt_next       = cnt + 1'b1;
          busy_next      = 1'b1;
        end else begin
          busy_next = 1'b0;
          done_next = 1'b1;
        end
      end
      RUN: begin
        if (bus.ClearReq) begin
          cnt_next  = '0;
          busy_next = 1'b1;
        end else if (win_valid) begin
          grant0_next    = ~winner;
          grant1_next    = winner;
          last_next      = winner;
          reg_no_next    = win_reg;
          data_next      = win_data;
          // Writes to register 0 are consumed but suppressed when protection is on.
          reg_write_next = !(ZERO_PROTECT && (win_reg == '0));
        end
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  assign bus.Grant0     = grant0_q;
  assign bus.Grant1     = grant1_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.WriteRegNo = reg_no_q;
  assign bus.WriteData  = data_q;
  assign bus.Busy       = busy_q;
  assign bus.ClearDone  = done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: expected write-port activity is queued as
// stimulus is driven and compared by a monitor as grants and writes appear.
module tb_regfile_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  regfile_write_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_scheduler #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .ZERO_PROTECT(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] rf[NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic g0, input logic g1, input logic rw,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.g0 = g0; e.g1 = g1; e.rw = rw; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void push_sweep();
    for (int i = 0; i < NR; i++) push(1'b0, 1'b0, 1'b1, AW'(i), '0);
  endfunction

  // Monitor: checks every grant/write against the queue and mirrors writes into rf.
  always @(negedge Clock) begin
    check("single_grant", bus.Grant0 & bus.Grant1, 0);
    if (bus.Grant0 || bus.Grant1 || bus.RegWrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.Grant0, bus.Grant1, bus.RegWrite}, 3'b000);
      end else begin
        check("wr_grant0", bus.Grant0,     exp_q[0].g0);
        check("wr_grant1", bus.Grant1,     exp_q[0].g1);
        check("wr_regwr",  bus.RegWrite,   exp_q[0].rw);
        check("wr_regno",  bus.WriteRegNo, exp_q[0].addr);
        check("wr_data",   bus.WriteData,  exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (bus.RegWrite) rf[bus.WriteRegNo] <= bus.WriteData;
    end
  end

  task automatic check_reset(input string tag);
    check(tag, {bus.RegWrite, bus.Grant0, bus.Grant1, bus.ClearDone, bus.Busy,
                bus.WriteRegNo, bus.WriteData},
               {4'b0000, 1'b1, 5'd0, 32'd0});
  endtask

  task automatic check_rf_zero(input string tag);
    int nz = 0;
    for (int i = 0; i < NR; i++) if (rf[i] !== '0) nz++;
    check(tag, nz, 0);
  endtask

  task automatic wait_grant(input string tag, input bit which, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clock);
      seen = which ? bus.Grant1 : bus.Grant0;
    end
    check(tag, seen, 1);
  endtask

  // Counts negedges from now; ClearDone is expected on the exp-th one.
  task automatic wait_clear_done(input string tag, input int exp);
    int   at        = 0;
    logic prev_busy = 1'b0;
    for (int i = 1; i <= exp + 4 && at == 0; i++) begin
      @(negedge Clock);
      if (bus.ClearDone) at = i;
      else prev_busy = bus.Busy;
    end
    check({tag, "_cycle"}, at, exp);
    check({tag, "_busy_low"}, bus.Busy, 0);
    check({tag, "_busy_before"}, prev_busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ClearReq = 1'b0;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.WReg0 = '0;  bus.WReg1 = '0;
    bus.WData0 = '0; bus.WData1 = '0;
    Reset = 1'b1;

    // Reset for two cycles, then the power-on sweep.
    repeat (2) @(negedge Clock);
    check_reset("reset_state");
    Reset = 1'b0;
    push_sweep();
    wait_clear_done("init_sweep", 33);
    check_rf_zero("init_rf_zero");

    // Two continuous requesters alternate, starting with requester 0.
    bus.WReg0 = 5'd3; bus.WData0 = 32'h1111_0003;
    bus.WReg1 = 5'd4; bus.WData1 = 32'h2222_0004;
    bus.Req0 = 1'b1;  bus.Req1 = 1'b1;
    push(1'b1, 1'b0, 1'b1, 5'd3, 32'h1111_0003);
    push(1'b0, 1'b1, 1'b1, 5'd4, 32'h2222_0004);
    push(1'b1, 1'b0, 1'b1, 5'd3, 32'h1111_0003);
    push(1'b0, 1'b1, 1'b1, 5'd4, 32'h2222_0004);
    repeat (4) @(negedge Clock);
    check("alt_last_is_1", bus.Grant1, 1);
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    @(negedge Clock);
    check("alt_idle", {bus.Grant0, bus.Grant1, bus.RegWrite}, 3'b000);

    // Lone requester 0.
    bus.WReg0 = 5'd5; bus.WData0 = 32'h0000_00A5; bus.Req0 = 1'b1;
    push(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_00A5);
    wait_grant("lone_grant", 1'b0, 6);
    bus.Req0 = 1'b0;
    @(negedge Clock);
    check("lone_pulse", bus.Grant0, 0);
    check("lone_rf5", rf[5], 32'h0000_00A5);

    // Requester 1 targeting register 0 is consumed but not written.
    bus.WReg1 = 5'd0; bus.WData1 = 32'hFFFF_FFFF; bus.Req1 = 1'b1;
    push(1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
    wait_grant("zp_grant", 1'b1, 6);
    check("zp_regwrite", bus.RegWrite, 0);
    bus.Req1 = 1'b0;
    @(negedge Clock);
    check("zp_rf0", rf[0], 0);

    // Load registers 1..31 with their own index.
    for (int i = 1; i < NR; i++) begin
      bus.WReg0 = AW'(i); bus.WData0 = DW'(i); bus.Req0 = 1'b1;
      push(1'b1, 1'b0, 1'b1, AW'(i), DW'(i));
      wait_grant("load_grant", 1'b0, 6);
    end
    bus.Req0 = 1'b0;
    @(negedge Clock);
    check("load_rf17", rf[17], 17);
    check("load_rf31", rf[31], 31);

    // ClearReq together with Req0: sweep first, grant right after ClearDone.
    bus.WReg0 = 5'd7; bus.WData0 = 32'h0000_0077; bus.Req0 = 1'b1;
    bus.ClearReq = 1'b1;
    push_sweep();
    push(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0077);
    @(negedge Clock);
    bus.ClearReq = 1'b0;
    check("clr_no_grant", bus.Grant0, 0);
    check("clr_busy", bus.Busy, 1);
    wait_clear_done("clr_sweep", 33);
    check_rf_zero("clr_rf_zero");
    @(negedge Clock);
    check("clr_grant_after_done", bus.Grant0, 1);
    bus.Req0 = 1'b0;
    @(negedge Clock);
    check("clr_rf7", rf[7], 32'h0000_0077);

    // Reset while the sweep counter is at 17.
    bus.ClearReq = 1'b1;
    push_sweep();
    @(negedge Clock);
    bus.ClearReq = 1'b0;
    repeat (17) @(negedge Clock);
    check("mid_regno_16", bus.WriteRegNo, 16);
    Reset = 1'b1;
    @(negedge Clock);
    check_reset("mid_reset_state");
    exp_q.delete();
    Reset = 1'b0;
    push_sweep();
    wait_clear_done("mid_sweep", 33);
    check_rf_zero("mid_rf_zero");
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Sequencer and arbiter for the single write port of the 32 x 32-bit register file. After reset, or on command, it sweeps every register to zero. Otherwise it shares the write port between two writeback requesters, requester 0 (ALU) and requester 1 (load), using round-robin arbitration. It drives RegWrite, WriteRegNo and WriteData of the register file from registers, so all three are stable for a full Clock period.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register number width; register count = 2**ADDR_WIDTH
- ZERO_PROTECT, 1, when 1, requester writes to register 0 are consumed but not performed
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- ClearReq  in  1  single-cycle pulse that starts a zero sweep
- Req0 / Req1  in  1  write request, held until granted
- WReg0 / WReg1  in  ADDR_WIDTH  target register, stable while Req high
- WData0 / WData1  in  DATA_WIDTH  write data, stable while Req high
- Grant0 / Grant1  out  1  one-cycle pulse: request consumed this cycle
- RegWrite  out  1  write enable to register file
- WriteRegNo  out  ADDR_WIDTH  write register number
- WriteData  out  DATA_WIDTH  write data
- Busy  out  1  high while a sweep is in progress
- ClearDone  out  1  one-cycle pulse when a sweep completes

## Operation
- States: CLEAR, RUN. Sweep counter Cnt is ADDR_WIDTH+1 bits. Round-robin pointer Last is 1 bit and names the last granted requester.
- Reset (any state, any cycle) sets:
  - state CLEAR, Cnt=0, Last=1
  - RegWrite=0, WriteRegNo=0, WriteData=0
  - Grant0=Grant1=0, ClearDone=0, Busy=1
- Any in-flight request is dropped by Reset, with no grant.
- CLEAR, each edge with Cnt < 2**ADDR_WIDTH: RegWrite=1, WriteRegNo=Cnt, WriteData=0, then Cnt++.
  - The sweep writes register 0 regardless of ZERO_PROTECT.
- CLEAR, edge with Cnt = 2**ADDR_WIDTH: state goes to RUN, Busy=0, ClearDone=1 for that cycle, RegWrite=0.
- CLEAR ignores ClearReq and never grants. Requests wait.
- RUN, ClearReq sampled high: state goes to CLEAR, Cnt=0, Busy=1, no grant that edge.
  - ClearReq has priority over simultaneous requests.
- RUN, otherwise, a requester is eligible when its Req=1 and its Grant is not currently asserted. The Grant rule prevents double consumption while the requester is dropping Req.
  - One eligible requester: it wins.
  - Both eligible: the requester other than Last wins.
- On a win:
  - Grant of the winner = 1, Last = winner.
  - WriteRegNo = WReg of the winner, WriteData = WData of the winner.
  - RegWrite = 1, except RegWrite = 0 when ZERO_PROTECT=1 and WReg = 0. The Grant is still issued in that case.
- No winner: RegWrite=0, Grants=0. WriteRegNo and WriteData hold their previous values.
- Consequence: a lone requester holding Req continuously is granted every other cycle. Two continuous requesters alternate every cycle.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on outputs during cycle N+1.
- Grant and the corresponding RegWrite/WriteRegNo/WriteData appear in the same cycle.
- A requester must deassert Req, or present its next request, at the edge ending its Grant cycle.
- Sweep after Reset deasserts:
  - cycles 1..32 write registers 0..31
  - cycle 33 has ClearDone=1 and Busy=0
  - requests sampled at the edge ending cycle 33 give the earliest grant, in cycle 34
- Sweep latency is 2**ADDR_WIDTH + 1 cycles from the ClearReq or Reset edge to ClearDone.
- Reset asserted mid-sweep restarts at register 0 on the first edge with Reset low.
- WriteRegNo wraps only through Cnt. Cnt never exceeds 2**ADDR_WIDTH.

## Test plan
- Reset for 2 cycles, then release:
  - RegWrite=1 with WriteRegNo 0..31 and WriteData=0 in consecutive cycles
  - ClearDone pulses in cycle 33, Busy falls with it
  - all registers read back 0
- Req0 alone with WReg0=5, WData0=32'h0000_00A5, held:
  - Grant0 is a pulse, with RegWrite=1, WriteRegNo=5, WriteData=32'hA5
  - Req0 is dropped the next cycle
  - register 5 reads 32'hA5
- Req0 and Req1 continuously asserted with distinct data:
  - grants alternate, beginning with requester 0 after reset: 0,1,0,1
  - no cycle has both grants
- ZERO_PROTECT=1, Req1 with WReg1=0 and WData1=32'hFFFF_FFFF:
  - Grant1 pulses, RegWrite stays 0
  - register 0 reads 0
- ClearReq in the same cycle as Req0 (after registers 1..31 loaded with 1..31):
  - no Grant0 until after ClearDone
  - all registers read 0
  - Grant0 is issued in the cycle after ClearDone
- Reset asserted when sweep Cnt=17:
  - outputs return to reset values the next cycle
  - the sweep restarts at register 0 and ClearDone fires 33 cycles after release
